// File: rtl/gray_codec_seq.sv
// Bit-serial Gray<->binary converter, MSB first, one bit per clock.
// Handshake: ready in IDLE, busy while converting, a one-cycle done pulse with dout updated.
module gray_codec_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [WIDTH-1:0] x_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] res_s;
   logic [WIDTH-1:0] dout_r;
   logic [IW-1:0]    idx_r;
   logic             m_r;
   logic             p_r;
   logic             o_s;
   logic             p_s;
   logic             ready_r;
   logic             busy_r;
   logic             done_r;

   // Resolve the current bit and the running XOR carried to the next lower bit.
   always_comb begin
      o_s = x_r[idx_r] ^ p_r;
      // G2B carries the decoded bit, B2G carries the raw input bit.
      if (m_r) begin
         p_s = x_r[idx_r];
      end else begin
         p_s = o_s;
      end
      res_s = res_r;
      res_s[idx_r] = o_s;
   end

   // Next-state decode for the IDLE -> CONV -> DONE sequence.
   always_comb begin
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_CONV;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CONV: begin
            if (idx_r == {IW{1'b0}}) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_CONV;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         x_r     <= {WIDTH{1'b0}};
         m_r     <= 1'b0;
         idx_r   <= {IW{1'b0}};
         p_r     <= 1'b0;
         res_r   <= {WIDTH{1'b0}};
         dout_r  <= {WIDTH{1'b0}};
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == ST_IDLE);
         busy_r  <= (state_s == ST_CONV);
         done_r  <= (state_s == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  x_r   <= din;
                  m_r   <= mode;
                  idx_r <= IDX_MSB;
                  p_r   <= 1'b0;
                  res_r <= {WIDTH{1'b0}};
               end else begin
                  x_r <= x_r;
               end
            end
            ST_CONV: begin
               res_r <= res_s;
               p_r   <= p_s;
               // dout is only written once the last bit is known.
               if (idx_r == {IW{1'b0}}) begin
                  dout_r <= res_s;
               end else begin
                  idx_r <= idx_r - {{(IW-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               res_r <= res_r;
            end
            default: begin
               res_r <= res_r;
            end
         endcase
      end
   end

   assign ready = ready_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign dout  = dout_r;

endmodule

// File: tb/tb_gray_codec_seq.sv
// Randomised and directed bench for gray_codec_seq at WIDTH=4 and WIDTH=8,
// checked every cycle against a cycle-count model with arithmetic Gray formulas.
module tb_gray_codec_seq;

   logic       clk = 1'b0;
   logic       rst4 = 1'b1, start4 = 1'b0, mode4 = 1'b0;
   logic [3:0] din4 = 4'd0;
   logic       ready4, busy4, done4;
   logic [3:0] dout4;
   logic       rst8 = 1'b1, start8 = 1'b0, mode8 = 1'b0;
   logic [7:0] din8 = 8'd0;
   logic       ready8, busy8, done8;
   logic [7:0] dout8;

   gray_codec_seq #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .din(din4),
      .ready(ready4), .busy(busy4), .done(done4), .dout(dout4));

   gray_codec_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .din(din8),
      .ready(ready8), .busy(busy8), .done(done8), .dout(dout8));

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          W [2] = '{4, 8};
   // stimulus for the next edge, per DUT
   logic        s_rst [2] = '{1'b1, 1'b1};
   logic        s_start [2] = '{1'b0, 1'b0};
   logic        s_mode [2] = '{1'b0, 1'b0};
   logic [31:0] s_din [2] = '{32'd0, 32'd0};
   // model: mcnt = 0 idle, 1..W converting, W+1 done
   int          mcnt [2] = '{0, 0};
   logic [31:0] mx [2], mdout [2];
   logic        mm [2];
   bit          mvalid [2] = '{1'b0, 1'b0};
   // observed events
   int          done_cnt [2] = '{0, 0};
   int          last_done_edge [2] = '{0, 0};
   logic [31:0] last_dout [2];
   logic        prev_busy [2] = '{1'b0, 1'b0};
   bit          hold8 = 1'b0;
   int          q8 [$];

   function automatic logic [31:0] conv(logic [31:0] v, logic md, int w);
      logic [31:0] mask;
      logic [31:0] vv;
      logic [31:0] r;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      vv = v & mask;
      r = 32'd0;
      if (md) begin
         r = (vv ^ (vv >> 1)) & mask;
      end else begin
         for (int i = 0; i < w; i++) r[i] = ^(vv >> i);
      end
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic observe(int k, logic r, logic b, logic d, logic [31:0] dv);
      if (mvalid[k]) begin
         chk($sformatf("ready[w%0d]", W[k]), {31'd0, r}, {31'd0, mcnt[k] == 0});
         chk($sformatf("busy[w%0d]", W[k]), {31'd0, b}, {31'd0, (mcnt[k] >= 1) && (mcnt[k] <= W[k])});
         chk($sformatf("done[w%0d]", W[k]), {31'd0, d}, {31'd0, mcnt[k] == W[k] + 1});
         chk($sformatf("dout[w%0d]", W[k]), dv, mdout[k]);
         if (d === 1'b1) begin
            done_cnt[k]++;
            last_done_edge[k] = cyc - 1;
            last_dout[k] = dv;
         end
         if (b === 1'b1 && prev_busy[k] !== 1'b1 && k == 1 && hold8) q8.push_back(cyc - 1);
         prev_busy[k] = b;
      end
   endtask

   task automatic advance(int k);
      if (s_rst[k]) begin
         mcnt[k] = 0;
         mdout[k] = 32'd0;
         mvalid[k] = 1'b1;
      end else if (mcnt[k] == 0) begin
         if (s_start[k]) begin
            mcnt[k] = 1;
            mx[k] = s_din[k];
            mm[k] = s_mode[k];
         end
      end else if (mcnt[k] < W[k]) begin
         mcnt[k]++;
      end else if (mcnt[k] == W[k]) begin
         mcnt[k] = W[k] + 1;
         mdout[k] = conv(mx[k], mm[k], W[k]);
      end else begin
         mcnt[k] = 0;
      end
   endtask

   // check the current cycle, then apply stimulus for the coming edge (edge number = cyc)
   task automatic tick();
      @(negedge clk);
      cyc++;
      observe(0, ready4, busy4, done4, {28'd0, dout4});
      observe(1, ready8, busy8, done8, {24'd0, dout8});
      rst4 = s_rst[0]; start4 = s_start[0]; mode4 = s_mode[0]; din4 = s_din[0][3:0];
      rst8 = s_rst[1]; start8 = s_start[1]; mode8 = s_mode[1]; din8 = s_din[1][7:0];
      advance(0);
      advance(1);
   endtask

   task automatic run_one(int k, logic md, logic [31:0] dv);
      int n0;
      int acc;
      bit seen;
      n0 = done_cnt[k];
      s_start[k] = 1'b1; s_mode[k] = md; s_din[k] = dv;
      tick();
      acc = cyc;
      s_start[k] = 1'b0; s_mode[k] = ~md; s_din[k] = $urandom;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (done_cnt[k] != n0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL timeout[w%0d]: got no done expected done within 40 cycles", W[k]);
      end else begin
         chk($sformatf("latency[w%0d]", W[k]), last_done_edge[k] - acc, W[k]);
      end
   endtask

   initial begin
      logic [31:0] g;
      int n0;
      // reset
      tick(); tick();
      s_rst[0] = 1'b0; s_rst[1] = 1'b0;
      tick();
      tick();
      chk("reset ready4", {31'd0, ready4}, 32'd1);
      chk("reset dout8", {24'd0, dout8}, 32'd0);

      // directed literals
      run_one(0, 1'b0, 32'b0110);
      chk("g2b 0110", last_dout[0], 32'b0100);
      run_one(0, 1'b1, 32'b1011);
      chk("b2g 1011", last_dout[0], 32'b1110);
      run_one(1, 1'b0, 32'hFF);
      chk("g2b FF", last_dout[1], 32'hAA);

      // exhaustive sweep and round-trip at WIDTH=4
      for (int v = 0; v < 16; v++) begin
         for (int md = 0; md < 2; md++) begin
            run_one(0, md[0], v);
            chk("sweep", last_dout[0], conv(v, md[0], 4));
         end
         run_one(0, 1'b1, v);
         g = last_dout[0];
         run_one(0, 1'b0, g);
         chk("roundtrip", last_dout[0], v);
      end

      // start held high at WIDTH=8: accepts spaced WIDTH+2 apart
      hold8 = 1'b1;
      s_start[1] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_mode[1] = $urandom_range(0, 1);
         s_din[1] = $urandom;
         tick();
      end
      s_start[1] = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      hold8 = 1'b0;
      chk("held accepts", {31'd0, q8.size() >= 3}, 32'd1);
      for (int i = 1; i < q8.size(); i++) chk("accept spacing", q8[i] - q8[i-1], 32'd10);

      // start during CONV is ignored
      g = $urandom & 32'hF;
      n0 = done_cnt[0];
      s_start[0] = 1'b1; s_mode[0] = 1'b0; s_din[0] = g;
      tick();
      s_mode[0] = 1'b1; s_din[0] = ~g;
      tick(); tick();
      s_start[0] = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("ignored start done count", done_cnt[0] - n0, 32'd1);
      chk("ignored start result", last_dout[0], conv(g, 1'b0, 4));

      // reset during 2nd CONV cycle
      run_one(0, 1'b0, 32'b1000);
      chk("pre-abort dout", last_dout[0], 32'b1111);
      n0 = done_cnt[0];
      s_start[0] = 1'b1; s_mode[0] = 1'b0; s_din[0] = 32'd5;
      tick();
      s_start[0] = 1'b0;
      tick();
      s_rst[0] = 1'b1;
      tick();
      s_rst[0] = 1'b0;
      tick();
      chk("abort dout", {28'd0, dout4}, 32'd0);
      chk("abort ready", {31'd0, ready4}, 32'd1);
      for (int i = 0; i < 8; i++) tick();
      chk("abort no done", done_cnt[0] - n0, 32'd0);
      run_one(0, 1'b1, 32'b0110);
      chk("post-abort b2g", last_dout[0], 32'b0101);

      // dout held while idle with din toggling
      tick();
      for (int i = 0; i < 20; i++) begin
         s_din[0] = $urandom;
         tick();
         chk("hold dout", {28'd0, dout4}, 32'b0101);
      end

      // random traffic on both instances
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            s_rst[k] = ($urandom_range(0, 49) == 0);
            s_start[k] = $urandom_range(0, 1);
            s_mode[k] = $urandom_range(0, 1);
            s_din[k] = $urandom;
         end
         tick();
      end
      s_rst[0] = 1'b0; s_rst[1] = 1'b0; s_start[0] = 1'b0; s_start[1] = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
